idex_hazard_reg: RTL and testbench
==================================

// Module: idex_hazard_reg
// PURPOSE
//  ID/EX pipeline register with integrated load-use hazard detection. It captures the decoded
//  instruction from ID and drives the IDEX_Rs/IDEX_Rt fields consumed by the EX-stage forwarding unit.
//  A load-use hazard cannot be forwarded, so this block stalls PC and IF/ID and inserts a bubble.
//  A branch flush also inserts a bubble.
// PARAMETERS
//  DATA_W   32  operand/immediate width
//  REG_W     5  register-address width
//  CNT_W    16  stall-event counter width
// PORTS
//  Clk             in   1        rising-edge clock
//  Rst             in   1        synchronous reset, active-low
//  Flush           in   1        branch taken; discard ID instruction
//  IFID_Rs         in   REG_W    source reg A of instruction in ID
//  IFID_Rt         in   REG_W    source reg B of instruction in ID
//  ID_UsesRt       in   1        ID instruction reads Rt as a source (R-type, store, beq/bne)
//  ID_Rd           in   REG_W    destination reg, already RegDst-selected
//  ID_RegWrite     in   1        control
//  ID_MemRead      in   1        control
//  ID_MemWrite     in   1        control
//  ID_MemToReg     in   1        control
//  ID_ALUSrc       in   1        control
//  ID_ALUOp        in   4        control
//  ID_ReadData1    in   DATA_W   register-file port A
//  ID_ReadData2    in   DATA_W   register-file port B
//  ID_Imm          in   DATA_W   sign-extended immediate
//  IDEX_*          out  (same)   registered copies of every ID_* / IFID_Rs/Rt input
//  Stall           out  1        load-use hazard this cycle (combinational)
//  PC_Write        out  1        = ~Stall
//  IFID_Write      out  1        = ~Stall
//  Stall_Count     out  CNT_W    saturating count of stall cycles
// BEHAVIOUR
//  - Reset (Rst==0 at posedge): all IDEX_* = 0 (bubble); Stall_Count = 0.
//    Stall is then 0 because IDEX_MemRead==0.
//  - Hazard = IDEX_MemRead && IDEX_Rd!=0 && (IDEX_Rd==IFID_Rs || (ID_UsesRt && IDEX_Rd==IFID_Rt)).
//  - Stall = Hazard && !Flush. Flush wins because the ID instruction is discarded anyway.
//  - Each posedge, with Rst high:
//      Flush | Stall : load bubble. All control = 0, IDEX_Rd/Rs/Rt = 0, data = 0.
//      otherwise     : load every ID_* and IFID_Rs/Rt input. Latency is exactly 1 cycle.
//  - Stall lasts exactly 1 cycle per load. After the bubble, IDEX_MemRead==0, so the stalled
//    instruction advances on the next cycle and the forwarding unit resolves it from MEM/WB.
//  - Back-to-back loads: lw→lw(dependent)→use stalls once per dependent pair, never twice in a row.
//  - Rd==0 never hazards: a load to $zero must not stall.
//  - Stall_Count += 1 on each posedge where Stall==1. Saturates at 2^CNT_W-1 (no wrap).
//  - Reset mid-stall: the bubble is loaded, the count clears, and Stall drops in the same cycle.
// STRUCTURE
//  - Shared package pipe_pkg: ALUOP_* localparams, REG_ZERO=5'd0, and the bubble control word.
//    These are shared with the EX/MEM and MEM/WB registers.
//  - One natural sub-module: load_use_detect (pure combinational Hazard equation).
//    The register bank and counter stay in the top.
// TESTING
//  1 Reset: Rst=0 for 2 clk with arbitrary inputs -> all IDEX_*=0, Stall=0, Stall_Count=0.
//  2 Pass-through: ID_Rd=5, ID_ReadData1=32'hDEAD_BEEF, RegWrite=1 -> same values on IDEX_* one
//    clk later; PC_Write=1.
//  3 Load-use: lw $8 latched (IDEX_MemRead=1, IDEX_Rd=8), then IFID_Rs=8 -> Stall=1,
//    PC_Write=IFID_Write=0. Next clk: bubble latched, Stall=0, Stall_Count=1.
//  4 Rt rules: IDEX_Rd=9, IFID_Rt=9, ID_UsesRt=0 -> Stall=0.
//    Same with ID_UsesRt=1 -> Stall=1. IDEX_Rd=0 with Rs=0 -> Stall=0.
//  5 Flush priority: hazard condition plus Flush=1 -> Stall=0, bubble latched, count unchanged.
//  6 Saturation: CNT_W=2, force 5 consecutive independent stalls -> Stall_Count reads 1,2,3,3,3.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: ALU operation codes, the zero register and
// the bubble control word used by the ID/EX, EX/MEM and MEM/WB registers.
package pipe_pkg;

  localparam logic [3:0] ALUOP_ADD = 4'd0;
  localparam logic [3:0] ALUOP_SUB = 4'd1;
  localparam logic [3:0] ALUOP_AND = 4'd2;
  localparam logic [3:0] ALUOP_OR  = 4'd3;
  localparam logic [3:0] ALUOP_XOR = 4'd4;
  localparam logic [3:0] ALUOP_NOR = 4'd5;
  localparam logic [3:0] ALUOP_SLT = 4'd6;
  localparam logic [3:0] ALUOP_SLL = 4'd7;
  localparam logic [3:0] ALUOP_SRL = 4'd8;
  localparam logic [3:0] ALUOP_LUI = 4'd9;

  // Architectural $zero; a write to it is discarded, so it never creates a dependency.
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Control word carried down the pipeline.
  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic [3:0] alu_op;
  } ctrl_t;

  // A bubble is a no-op: nothing is written and memory is untouched.
  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/idex_hazard_reg_load_use_detect.sv
// Load-use hazard equation: the instruction in EX is a load whose result
// the instruction in ID needs before the load data is available.
module load_use_detect
  import pipe_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic             i_ex_mem_read,
  input  logic [REG_W-1:0] i_ex_rd,
  input  logic [REG_W-1:0] i_id_rs,
  input  logic [REG_W-1:0] i_id_rt,
  input  logic             i_id_uses_rt,
  output logic             o_hazard
);

  logic w_rd_nonzero;
  logic w_rs_match;
  logic w_rt_match;

  // Rt only counts when the ID instruction actually reads it as a source;
  // an I-type writing Rt must not stall on a stale match.
  always_comb begin
    w_rd_nonzero = (i_ex_rd != REG_W'(REG_ZERO));
    w_rs_match   = (i_ex_rd == i_id_rs);
    w_rt_match   = i_id_uses_rt && (i_ex_rd == i_id_rt);
    o_hazard     = i_ex_mem_read && w_rd_nonzero && (w_rs_match || w_rt_match);
  end

endmodule

// File: rtl/idex_hazard_reg.sv
// ID/EX pipeline register with load-use stall generation and a saturating
// stall-event counter. A stall or a branch flush loads a bubble into EX;
// a stall also freezes PC and IF/ID for that single cycle.
module idex_hazard_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Flush,
  input  logic [REG_W-1:0]  IFID_Rs,
  input  logic [REG_W-1:0]  IFID_Rt,
  input  logic              ID_UsesRt,
  input  logic [REG_W-1:0]  ID_Rd,
  input  logic              ID_RegWrite,
  input  logic              ID_MemRead,
  input  logic              ID_MemWrite,
  input  logic              ID_MemToReg,
  input  logic              ID_ALUSrc,
  input  logic [3:0]        ID_ALUOp,
  input  logic [DATA_W-1:0] ID_ReadData1,
  input  logic [DATA_W-1:0] ID_ReadData2,
  input  logic [DATA_W-1:0] ID_Imm,
  output logic [REG_W-1:0]  IDEX_Rs,
  output logic [REG_W-1:0]  IDEX_Rt,
  output logic              IDEX_UsesRt,
  output logic [REG_W-1:0]  IDEX_Rd,
  output logic              IDEX_RegWrite,
  output logic              IDEX_MemRead,
  output logic              IDEX_MemWrite,
  output logic              IDEX_MemToReg,
  output logic              IDEX_ALUSrc,
  output logic [3:0]        IDEX_ALUOp,
  output logic [DATA_W-1:0] IDEX_ReadData1,
  output logic [DATA_W-1:0] IDEX_ReadData2,
  output logic [DATA_W-1:0] IDEX_Imm,
  output logic              Stall,
  output logic              PC_Write,
  output logic              IFID_Write,
  output logic [CNT_W-1:0]  Stall_Count
);

  ctrl_t             r_ctrl;
  logic [REG_W-1:0]  r_rs;
  logic [REG_W-1:0]  r_rt;
  logic              r_uses_rt;
  logic [REG_W-1:0]  r_rd;
  logic [DATA_W-1:0] r_rd1;
  logic [DATA_W-1:0] r_rd2;
  logic [DATA_W-1:0] r_imm;
  logic [CNT_W-1:0]  r_stall_count;

  ctrl_t             w_id_ctrl;
  logic              w_hazard;
  logic              w_stall;
  logic              w_bubble;

  load_use_detect #(
    .REG_W (REG_W)
  ) u_load_use_detect (
    .i_ex_mem_read (r_ctrl.mem_read),
    .i_ex_rd       (r_rd),
    .i_id_rs       (IFID_Rs),
    .i_id_rt       (IFID_Rt),
    .i_id_uses_rt  (ID_UsesRt),
    .o_hazard      (w_hazard)
  );

  // Flush beats stall: the ID instruction is being discarded, so holding it is pointless.
  always_comb begin
    w_id_ctrl.reg_write  = ID_RegWrite;
    w_id_ctrl.mem_read   = ID_MemRead;
    w_id_ctrl.mem_write  = ID_MemWrite;
    w_id_ctrl.mem_to_reg = ID_MemToReg;
    w_id_ctrl.alu_src    = ID_ALUSrc;
    w_id_ctrl.alu_op     = ID_ALUOp;
    w_stall              = w_hazard && !Flush;
    w_bubble             = w_stall || Flush;
  end

  // Pipeline register: reset and bubble both leave a no-op in EX.
  always_ff @(posedge Clk) begin
    if (!Rst || w_bubble) begin
      r_ctrl    <= CTRL_BUBBLE;
      r_rs      <= '0;
      r_rt      <= '0;
      r_uses_rt <= 1'b0;
      r_rd      <= '0;
      r_rd1     <= '0;
      r_rd2     <= '0;
      r_imm     <= '0;
    end else begin
      r_ctrl    <= w_id_ctrl;
      r_rs      <= IFID_Rs;
      r_rt      <= IFID_Rt;
      r_uses_rt <= ID_UsesRt;
      r_rd      <= ID_Rd;
      r_rd1     <= ID_ReadData1;
      r_rd2     <= ID_ReadData2;
      r_imm     <= ID_Imm;
    end
  end

  // Stall-cycle counter, holds at all-ones instead of wrapping.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_stall_count <= '0;
    end else if (w_stall && (r_stall_count != {CNT_W{1'b1}})) begin
      r_stall_count <= r_stall_count + CNT_W'(1);
    end
  end

  assign IDEX_Rs        = r_rs;
  assign IDEX_Rt        = r_rt;
  assign IDEX_UsesRt    = r_uses_rt;
  assign IDEX_Rd        = r_rd;
  assign IDEX_RegWrite  = r_ctrl.reg_write;
  assign IDEX_MemRead   = r_ctrl.mem_read;
  assign IDEX_MemWrite  = r_ctrl.mem_write;
  assign IDEX_MemToReg  = r_ctrl.mem_to_reg;
  assign IDEX_ALUSrc    = r_ctrl.alu_src;
  assign IDEX_ALUOp     = r_ctrl.alu_op;
  assign IDEX_ReadData1 = r_rd1;
  assign IDEX_ReadData2 = r_rd2;
  assign IDEX_Imm       = r_imm;
  assign Stall          = w_stall;
  assign PC_Write       = ~w_stall;
  assign IFID_Write     = ~w_stall;
  assign Stall_Count    = r_stall_count;

endmodule

// File: tb/tb_idex_hazard_reg.sv
// Bench for idex_hazard_reg: reset, a directed vector table, reset-mid-stall
// and counter saturation sequences, then randomized traffic against a model.
// A second instance with a 2-bit counter shares all inputs.
module tb_idex_hazard_reg;

  typedef struct packed {
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        uses_rt;
    logic [4:0]  rd;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        memtoreg;
    logic        alusrc;
    logic [3:0]  aluop;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
  } instr_t;

  typedef struct {
    instr_t      ins;
    bit          flush;
    bit          exp_stall;
    logic [15:0] exp_cnt;
  } vec_t;

  // clock / reset
  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic        Rst, Flush, ID_UsesRt, ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemToReg, ID_ALUSrc;
  logic [4:0]  IFID_Rs, IFID_Rt, ID_Rd;
  logic [3:0]  ID_ALUOp;
  logic [31:0] ID_ReadData1, ID_ReadData2, ID_Imm;

  logic [4:0]  IDEX_Rs, IDEX_Rt, IDEX_Rd;
  logic        IDEX_UsesRt, IDEX_RegWrite, IDEX_MemRead, IDEX_MemWrite, IDEX_MemToReg, IDEX_ALUSrc;
  logic [3:0]  IDEX_ALUOp;
  logic [31:0] IDEX_ReadData1, IDEX_ReadData2, IDEX_Imm;
  logic        Stall, PC_Write, IFID_Write;
  logic [15:0] Stall_Count;

  logic [4:0]  s_rs, s_rt, s_rd;
  logic        s_uses_rt, s_regwrite, s_memread, s_memwrite, s_memtoreg, s_alusrc;
  logic [3:0]  s_aluop;
  logic [31:0] s_rd1, s_rd2, s_imm;
  logic        s_stall, s_pc_write, s_ifid_write;
  logic [1:0]  s_count;

  idex_hazard_reg dut (
    .Clk(Clk), .Rst(Rst), .Flush(Flush), .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt),
    .ID_UsesRt(ID_UsesRt), .ID_Rd(ID_Rd), .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead),
    .ID_MemWrite(ID_MemWrite), .ID_MemToReg(ID_MemToReg), .ID_ALUSrc(ID_ALUSrc),
    .ID_ALUOp(ID_ALUOp), .ID_ReadData1(ID_ReadData1), .ID_ReadData2(ID_ReadData2), .ID_Imm(ID_Imm),
    .IDEX_Rs(IDEX_Rs), .IDEX_Rt(IDEX_Rt), .IDEX_UsesRt(IDEX_UsesRt), .IDEX_Rd(IDEX_Rd),
    .IDEX_RegWrite(IDEX_RegWrite), .IDEX_MemRead(IDEX_MemRead), .IDEX_MemWrite(IDEX_MemWrite),
    .IDEX_MemToReg(IDEX_MemToReg), .IDEX_ALUSrc(IDEX_ALUSrc), .IDEX_ALUOp(IDEX_ALUOp),
    .IDEX_ReadData1(IDEX_ReadData1), .IDEX_ReadData2(IDEX_ReadData2), .IDEX_Imm(IDEX_Imm),
    .Stall(Stall), .PC_Write(PC_Write), .IFID_Write(IFID_Write), .Stall_Count(Stall_Count)
  );

  idex_hazard_reg #(.CNT_W(2)) dut_sat (
    .Clk(Clk), .Rst(Rst), .Flush(Flush), .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt),
    .ID_UsesRt(ID_UsesRt), .ID_Rd(ID_Rd), .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead),
    .ID_MemWrite(ID_MemWrite), .ID_MemToReg(ID_MemToReg), .ID_ALUSrc(ID_ALUSrc),
    .ID_ALUOp(ID_ALUOp), .ID_ReadData1(ID_ReadData1), .ID_ReadData2(ID_ReadData2), .ID_Imm(ID_Imm),
    .IDEX_Rs(s_rs), .IDEX_Rt(s_rt), .IDEX_UsesRt(s_uses_rt), .IDEX_Rd(s_rd),
    .IDEX_RegWrite(s_regwrite), .IDEX_MemRead(s_memread), .IDEX_MemWrite(s_memwrite),
    .IDEX_MemToReg(s_memtoreg), .IDEX_ALUSrc(s_alusrc), .IDEX_ALUOp(s_aluop),
    .IDEX_ReadData1(s_rd1), .IDEX_ReadData2(s_rd2), .IDEX_Imm(s_imm),
    .Stall(s_stall), .PC_Write(s_pc_write), .IFID_Write(s_ifid_write), .Stall_Count(s_count)
  );

  // scoreboard / reference model state
  int     n_checks = 0;
  int     n_errors = 0;
  instr_t m_ex;
  int     m_cnt;
  int     m_cnt_s;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic instr_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                                input logic [4:0] rd, input logic memread, input logic [31:0] d);
    instr_t t;
    t.rs = rs; t.rt = rt; t.uses_rt = uses; t.rd = rd;
    t.regwrite = 1'b1; t.memread = memread; t.memwrite = 1'b0;
    t.memtoreg = memread; t.alusrc = memread; t.aluop = memread ? 4'd0 : 4'd1;
    t.rd1 = d; t.rd2 = ~d; t.imm = d ^ 32'h0000_1234;
    return t;
  endfunction

  function automatic instr_t rand_ins();
    instr_t t;
    t.rs = 5'($urandom_range(0, 3)); t.rt = 5'($urandom_range(0, 3));
    t.uses_rt = 1'($urandom); t.rd = 5'($urandom_range(0, 3));
    t.regwrite = 1'($urandom); t.memread = 1'($urandom); t.memwrite = 1'($urandom);
    t.memtoreg = 1'($urandom); t.alusrc = 1'($urandom); t.aluop = 4'($urandom);
    t.rd1 = $urandom; t.rd2 = $urandom; t.imm = $urandom;
    return t;
  endfunction

  // The ID instruction needs a register that a load in EX has not produced yet.
  function automatic bit m_hazard(input instr_t id);
    return m_ex.memread && (m_ex.rd != 0) &&
           ((m_ex.rd == id.rs) || (id.uses_rt && (m_ex.rd == id.rt)));
  endfunction

  function automatic instr_t act_ex();
    instr_t t;
    t.rs = IDEX_Rs; t.rt = IDEX_Rt; t.uses_rt = IDEX_UsesRt; t.rd = IDEX_Rd;
    t.regwrite = IDEX_RegWrite; t.memread = IDEX_MemRead; t.memwrite = IDEX_MemWrite;
    t.memtoreg = IDEX_MemToReg; t.alusrc = IDEX_ALUSrc; t.aluop = IDEX_ALUOp;
    t.rd1 = IDEX_ReadData1; t.rd2 = IDEX_ReadData2; t.imm = IDEX_Imm;
    return t;
  endfunction

  function automatic instr_t act_ex_s();
    instr_t t;
    t.rs = s_rs; t.rt = s_rt; t.uses_rt = s_uses_rt; t.rd = s_rd;
    t.regwrite = s_regwrite; t.memread = s_memread; t.memwrite = s_memwrite;
    t.memtoreg = s_memtoreg; t.alusrc = s_alusrc; t.aluop = s_aluop;
    t.rd1 = s_rd1; t.rd2 = s_rd2; t.imm = s_imm;
    return t;
  endfunction

  // driver: one ID instruction per cycle, applied just after the falling edge
  task automatic drive(input instr_t ins, input bit flush, input bit rst);
    Rst = rst; Flush = flush;
    IFID_Rs = ins.rs; IFID_Rt = ins.rt; ID_UsesRt = ins.uses_rt; ID_Rd = ins.rd;
    ID_RegWrite = ins.regwrite; ID_MemRead = ins.memread; ID_MemWrite = ins.memwrite;
    ID_MemToReg = ins.memtoreg; ID_ALUSrc = ins.alusrc; ID_ALUOp = ins.aluop;
    ID_ReadData1 = ins.rd1; ID_ReadData2 = ins.rd2; ID_Imm = ins.imm;
  endtask

  task automatic cycle(input instr_t ins, input bit flush, input bit rst, input bit chk_pre,
                       output logic obs_stall);
    bit exp_stall;
    drive(ins, flush, rst);
    #2;
    obs_stall = Stall;
    exp_stall = !flush && m_hazard(ins);
    if (chk_pre) begin
      check("stall", {127'd0, Stall}, {127'd0, exp_stall});
      check("pc_ifid_write", {126'd0, PC_Write, IFID_Write}, {126'd0, !exp_stall, !exp_stall});
      check("stall_sat_inst", {127'd0, s_stall}, {127'd0, exp_stall});
    end
    if (!rst) begin
      m_ex = '0; m_cnt = 0; m_cnt_s = 0;
    end else if (flush || exp_stall) begin
      m_ex = '0;
      if (exp_stall) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt_s < 3) m_cnt_s++;
      end
    end else begin
      m_ex = ins;
    end
    @(posedge Clk);
    @(negedge Clk);
    check("idex", {6'd0, act_ex()}, {6'd0, m_ex});
    check("idex_sat_inst", {6'd0, act_ex_s()}, {6'd0, m_ex});
    check("stall_count", {112'd0, Stall_Count}, 128'(m_cnt));
    check("stall_count_sat", {126'd0, s_count}, 128'(m_cnt_s));
    check("stall_after_edge", {127'd0, Stall}, {127'd0, !flush && m_hazard(ins)});
  endtask

  vec_t   tbl[18];
  logic   obs;
  instr_t t_ins;
  logic [1:0] sat_exp[5];

  initial begin
    // reset: two cycles with arbitrary inputs
    cycle(rand_ins(), 1'b0, 1'b0, 1'b0, obs);
    cycle(rand_ins(), 1'b0, 1'b0, 1'b1, obs);
    check("reset_idex_zero", {6'd0, act_ex()}, 128'd0);
    check("reset_count_zero", {112'd0, Stall_Count}, 128'd0);

    // directed vectors: {instruction, flush, expected stall, expected count after edge}
    tbl[0]  = '{mk(1, 2, 1, 5, 0, 32'hDEAD_BEEF), 0, 0, 0};  // pass-through
    tbl[1]  = '{mk(5, 6, 1, 8, 0, 32'h1111_0000), 0, 0, 0};
    tbl[1].ins.memread = 1'b1;                                 // lw $8, rs matches non-load rd 5
    tbl[2]  = '{mk(8, 3, 1, 10, 0, 32'h2222_0000), 0, 1, 1};  // uses $8 -> stall
    tbl[3]  = '{mk(8, 3, 1, 10, 0, 32'h2222_0000), 0, 0, 1};  // re-issued, proceeds
    tbl[4]  = '{mk(0, 0, 0, 9, 1, 32'h3333_0000), 0, 0, 1};   // lw $9
    tbl[5]  = '{mk(1, 9, 0, 11, 0, 32'h4444_0000), 0, 0, 1};  // rt=9 but not read
    tbl[6]  = '{mk(0, 0, 0, 9, 1, 32'h5555_0000), 0, 0, 1};   // lw $9
    tbl[7]  = '{mk(2, 9, 1, 11, 0, 32'h6666_0000), 0, 1, 2};  // rt=9 read -> stall
    tbl[8]  = '{mk(3, 3, 0, 0, 1, 32'h7777_0000), 0, 0, 2};   // lw $0
    tbl[9]  = '{mk(0, 0, 1, 4, 0, 32'h8888_0000), 0, 0, 2};   // reads $0 -> never stalls
    tbl[10] = '{mk(1, 1, 0, 12, 1, 32'h9999_0000), 0, 0, 2};  // lw $12
    tbl[11] = '{mk(12, 1, 0, 13, 0, 32'hAAAA_0000), 1, 0, 2}; // hazard but flushed
    tbl[12] = '{mk(12, 1, 0, 13, 0, 32'hBBBB_0000), 0, 0, 2}; // after flush bubble
    tbl[13] = '{mk(1, 1, 0, 4, 1, 32'hCCCC_0000), 0, 0, 2};   // lw $4
    tbl[14] = '{mk(4, 2, 0, 5, 1, 32'hDDDD_0000), 0, 1, 3};   // lw $5 depends on $4
    tbl[15] = '{mk(4, 2, 0, 5, 1, 32'hDDDD_0000), 0, 0, 3};   // proceeds
    tbl[16] = '{mk(5, 5, 1, 6, 0, 32'hEEEE_0000), 0, 1, 4};   // uses $5 -> stall
    tbl[17] = '{mk(5, 5, 1, 6, 0, 32'hEEEE_0000), 0, 0, 4};   // proceeds
    for (int i = 0; i < 18; i++) begin
      cycle(tbl[i].ins, tbl[i].flush, 1'b1, 1'b1, obs);
      check($sformatf("vec%0d_stall", i), {127'd0, obs}, {127'd0, tbl[i].exp_stall});
      check($sformatf("vec%0d_count", i), {112'd0, Stall_Count}, {112'd0, tbl[i].exp_cnt});
    end
    check("passthru_rd1_held", 128'(IDEX_ReadData1), 128'(32'hEEEE_0000));

    // reset in the middle of a stall
    cycle(mk(1, 1, 0, 7, 1, 32'h0707_0707), 1'b0, 1'b1, 1'b1, obs);
    cycle(mk(7, 0, 0, 3, 0, 32'h0303_0303), 1'b0, 1'b0, 1'b1, obs);
    check("midstall_stall_before", {127'd0, obs}, 128'd1);
    check("midstall_count_clear", {112'd0, Stall_Count}, 128'd0);
    check("midstall_stall_drops", {127'd0, Stall}, 128'd0);

    // five independent load-use stalls on the 2-bit and 16-bit counters
    sat_exp[0] = 2'd1; sat_exp[1] = 2'd2; sat_exp[2] = 2'd3; sat_exp[3] = 2'd3; sat_exp[4] = 2'd3;
    for (int k = 0; k < 5; k++) begin
      cycle(mk(0, 0, 0, 5'(k + 1), 1, 32'(k)), 1'b0, 1'b1, 1'b1, obs);
      cycle(mk(5'(k + 1), 0, 0, 20, 0, 32'(k)), 1'b0, 1'b1, 1'b1, obs);
      check($sformatf("sat%0d_count2", k), {126'd0, s_count}, {126'd0, sat_exp[k]});
      check($sformatf("sat%0d_count16", k), {112'd0, Stall_Count}, 128'(k + 1));
    end

    // randomized traffic with occasional flush and reset
    for (int n = 0; n < 400; n++) begin
      t_ins = rand_ins();
      cycle(t_ins, ($urandom_range(0, 9) == 0), ($urandom_range(0, 49) != 0), 1'b1, obs);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
